booth_shift_reg_n: RTL and testbench

//  Parametrised shift register for the Booth multiplier datapath and later serial arithmetic units.

---
 rtl/booth_shift_reg_n_pkg.sv | 17 +
 rtl/booth_shift_reg_n_step.sv | 24 ++
 rtl/booth_shift_reg_n.sv | 93 +++++++++
 tb/tb_booth_shift_reg_n.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_shift_reg_n_pkg.sv
// Shared shift-mode and FSM state encodings for the Booth shift register.
package booth_shift_reg_n_pkg;

  typedef enum logic [1:0] {
    MODE_SRL = 2'b00,
    MODE_SRA = 2'b01,
    MODE_SLL = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/booth_shift_reg_n_step.sv
// Combinational one-step shifter shared by single-step and multi-cycle paths.
module booth_shift_reg_n_step
  import booth_shift_reg_n_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            mode,
  input  logic             sd_in,
  output logic [WIDTH-1:0] q_nxt
);

  always_comb begin
    q_nxt = q;
    unique case (mode)
      MODE_SRL: q_nxt = {sd_in, q[WIDTH-1:1]};
      MODE_SRA: q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_SLL: q_nxt = {q[WIDTH-2:0], sd_in};
      MODE_ROR: q_nxt = {q[0], q[WIDTH-1:1]};
      default:  q_nxt = q;
    endcase
  end

endmodule

// File: rtl/booth_shift_reg_n.sv
// Booth datapath shift register: load, single step, and counted multi-step shift.
module booth_shift_reg_n
  import booth_shift_reg_n_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d_in,
  input  logic             en,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             sd_in,
  output logic [WIDTH-1:0] q,
  output logic             sd_out,
  output logic             busy,
  output logic             done
);

  state_e           state, state_nxt;
  mode_e            mode_r, mode_r_nxt;
  mode_e            mode_sel;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] amt_clamp;
  logic [WIDTH-1:0] q_nxt, q_step;

  localparam logic [CNT_W-1:0] WMAX = CNT_W'(WIDTH);

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign mode_sel  = busy ? mode_r : mode_e'(mode);
  assign sd_out    = (mode_sel == MODE_SLL) ? q[WIDTH-1] : q[0];
  assign amt_clamp = (amount > WMAX) ? WMAX : amount;

  booth_shift_reg_n_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q     (q),
    .mode  (mode_sel),
    .sd_in (sd_in),
    .q_nxt (q_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      mode_r <= MODE_SRL;
      cnt    <= '0;
      q      <= '0;
    end else begin
      state  <= state_nxt;
      mode_r <= mode_r_nxt;
      cnt    <= cnt_nxt;
      q      <= q_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mode_r_nxt = mode_r;
    cnt_nxt    = cnt;
    q_nxt      = q;
    if (ld) begin
      // load always wins; from SHIFT/DONE it aborts without a done pulse
      q_nxt     = d_in;
      state_nxt = ST_IDLE;
      if (state != ST_IDLE) cnt_nxt = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            mode_r_nxt = mode_e'(mode);
            cnt_nxt    = amt_clamp;
            state_nxt  = (amt_clamp == '0) ? ST_DONE : ST_SHIFT;
          end else if (en) begin
            q_nxt = q_step;
          end
        end
        ST_SHIFT: begin
          q_nxt   = q_step;
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_shift_reg_n.sv
// Directed scoreboard bench for booth_shift_reg_n (WIDTH=8, CNT_W=4).
module tb_booth_shift_reg_n;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ld, en, start, sd_in;
  logic [7:0] d_in;
  logic [1:0] mode;
  logic [3:0] amount;
  logic [7:0] q;
  logic       sd_out, busy, done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  booth_shift_reg_n #(
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (ld),
    .d_in    (d_in),
    .en      (en),
    .start   (start),
    .mode    (mode),
    .amount  (amount),
    .sd_in   (sd_in),
    .q       (q),
    .sd_out  (sd_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // counts busy samples and done pulses until idle, bounded
  task automatic run_count(output int busy_n, output int done_n);
    int n;
    busy_n = 0;
    done_n = 0;
    n = 0;
    while (busy && n < 40) begin
      busy_n++;
      if (done) done_n++;
      step();
      n++;
    end
  endtask

  task automatic load(input logic [7:0] v);
    ld   = 1'b1;
    d_in = v;
    step();
    ld   = 1'b0;
  endtask

  int bn, dn;

  initial begin
    reset_n = 1'b0;
    ld = 0; en = 0; start = 0; sd_in = 0;
    d_in = '0; mode = 2'b00; amount = '0;
    #3;
    push("rst_q", 16'h00);    pop_chk({8'h0, q});
    push("rst_busy", 16'h0);  pop_chk({15'h0, busy});
    push("rst_done", 16'h0);  pop_chk({15'h0, done});
    push("rst_sdout", 16'h0); pop_chk({15'h0, sd_out});
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // single-step SRL
    push("ld_a5", 16'hA5);
    load(8'hA5);
    pop_chk({8'h0, q});
    en = 1; mode = 2'b00; sd_in = 1;
    #1;
    push("srl_sdout", 16'h1); pop_chk({15'h0, sd_out});
    push("srl_q", 16'hD2);
    step();
    en = 0;
    pop_chk({8'h0, q});

    // SRA by 3
    load(8'h80);
    start = 1; mode = 2'b01; amount = 4'd3;
    step();
    start = 0;
    push("sra_q0", 16'h80); pop_chk({8'h0, q});
    push("sra_busy_n", 16'd4);
    push("sra_done_n", 16'd1);
    push("sra_q", 16'hF0);
    run_count(bn, dn);
    pop_chk(16'(bn));
    pop_chk(16'(dn));
    pop_chk({8'h0, q});

    // ROR with clamp 12 -> 8, sd_out follows mode_r while busy
    load(8'h81);
    start = 1; mode = 2'b11; amount = 4'd12;
    step();
    start = 0; mode = 2'b10;
    push("ror_q1", 16'hC0);
    push("ror_sdout", 16'h0);
    step();
    pop_chk({8'h0, q});
    pop_chk({15'h0, sd_out});
    push("ror_busy_n", 16'd8);
    push("ror_done_n", 16'd1);
    push("ror_q", 16'h81);
    run_count(bn, dn);
    pop_chk(16'(bn));
    pop_chk(16'(dn));
    pop_chk({8'h0, q});

    // amount 0 -> straight to DONE
    load(8'h01);
    start = 1; mode = 2'b10; amount = 4'd0;
    step();
    start = 0;
    push("z_busy_n", 16'd1);
    push("z_done_n", 16'd1);
    push("z_q", 16'h01);
    run_count(bn, dn);
    pop_chk(16'(bn));
    pop_chk(16'(dn));
    pop_chk({8'h0, q});

    // ld aborts mid-shift at cnt=2
    load(8'h0F);
    start = 1; mode = 2'b00; amount = 4'd5; sd_in = 0;
    step();
    start = 0;
    step(); step(); step();
    push("abort_pre_q", 16'h01); pop_chk({8'h0, q});
    push("abort_q", 16'h3C);
    push("abort_busy", 16'h0);
    push("abort_done", 16'h0);
    load(8'h3C);
    pop_chk({8'h0, q});
    pop_chk({15'h0, busy});
    pop_chk({15'h0, done});
    push("abort_done2", 16'h0);
    step();
    pop_chk({15'h0, done});

    // async reset mid-operation
    load(8'hAA);
    start = 1; mode = 2'b00; amount = 4'd6;
    step();
    start = 0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    push("arst_q", 16'h00);   pop_chk({8'h0, q});
    push("arst_busy", 16'h0); pop_chk({15'h0, busy});
    push("arst_done", 16'h0); pop_chk({15'h0, done});
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // ld beats start and en on the same edge
    ld = 1; en = 1; start = 1; d_in = 8'h5A; mode = 2'b00; amount = 4'd3;
    step();
    ld = 0; en = 0; start = 0;
    push("pri_q", 16'h5A);   pop_chk({8'h0, q});
    push("pri_busy", 16'h0); pop_chk({15'h0, busy});
    step();
    push("pri_q2", 16'h5A);  pop_chk({8'h0, q});

    // en/start ignored while busy
    load(8'h80);
    start = 1; mode = 2'b00; amount = 4'd2; sd_in = 0;
    step();
    en = 1; start = 1; mode = 2'b10; amount = 4'd8;
    step();
    push("ign_q1", 16'h40); pop_chk({8'h0, q});
    step();
    push("ign_q2", 16'h20);  pop_chk({8'h0, q});
    push("ign_done", 16'h1); pop_chk({15'h0, done});
    en = 0; start = 0;
    step();
    push("ign_busy", 16'h0); pop_chk({15'h0, busy});
    push("ign_q3", 16'h20);  pop_chk({8'h0, q});

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
